// File: rtl/spi_controller.sv
// SPI mode-0 controller: one start pulse runs one WIDTH-bit MSB-first transfer
// and returns the received word with a one-cycle done strobe.
module spi_controller #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4,
    parameter int CNTW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] txdata,
    output logic [WIDTH-1:0] rxdata,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]       state;
    logic [CNTW-1:0]  divcnt;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic             div_last;

    assign div_last = (divcnt == CNTW'(CLKDIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            divcnt <= '0;
            bitcnt <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            rxdata <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sclk   <= 1'b0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // tx_sr holds the bits still to send; its MSB is the next mosi value
                        tx_sr  <= {txdata[WIDTH-2:0], 1'b0};
                        mosi   <= txdata[WIDTH-1];
                        cs     <= 1'b0;
                        busy   <= 1'b1;
                        bitcnt <= '0;
                        divcnt <= '0;
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (div_last) begin
                        sclk   <= 1'b1;
                        rx_sr  <= {rx_sr[WIDTH-2:0], miso};
                        divcnt <= '0;
                        state  <= HIGH;
                    end else begin
                        divcnt <= divcnt + CNTW'(1);
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        sclk   <= 1'b0;
                        divcnt <= '0;
                        if (bitcnt == BW'(WIDTH - 1)) begin
                            state <= HOLD;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            mosi   <= tx_sr[WIDTH-1];
                            tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
                            state  <= LOW;
                        end
                    end else begin
                        divcnt <= divcnt + CNTW'(1);
                    end
                end
                default: begin
                    if (div_last) begin
                        cs     <= 1'b1;
                        rxdata <= rx_sr;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        mosi   <= 1'b0;
                        divcnt <= '0;
                        state  <= IDLE;
                    end else begin
                        divcnt <= divcnt + CNTW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) controller that drives the other end of the team's SPI peripheral shift-register path.
- Generates sclk, cs and mosi from the system clock, and captures miso.
- One start pulse runs one full WIDTH-bit, MSB-first transfer and returns the received word with a one-cycle done strobe.
- Used by on-board test harnesses and by the CPU-side bus bridge to talk to the peripheral.

Parameters:
- WIDTH, 8, bits per transfer (>=2).
- CLKDIV, 4, system-clock cycles per sclk half-period (>=1). sclk period = 2*CLKDIV cycles.
- CNTW, 8, width of the half-period counter; must hold CLKDIV-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transfer; sampled only when busy=0.
- txdata  in  WIDTH  word to send; latched on the accepting start cycle.
- rxdata  out  WIDTH  last received word; updated only at transfer end.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse; rxdata is valid in that cycle.
- sclk  out  1  serial clock; idles low.
- cs  out  1  active-low chip select; idles high.
- mosi  out  1  serial data to the peripheral; MSB first.
- miso  in  1  serial data from the peripheral; changes after sclk falling edges.

Behaviour:
- All outputs are registers (no combinational paths from inputs to outputs).
- Reset values: state=IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rxdata=0, all counters 0.
- A reset mid-transfer aborts on that edge: cs=1, sclk=0, and done does not pulse.
- States: IDLE, LOW, HIGH, HOLD.
- IDLE:
  - cs=1, sclk=0, busy=0.
  - If start=1: latch txdata into the tx shift register, cs<=0, mosi<=txdata[WIDTH-1], busy<=1, bitcnt<=0, divcnt<=0, go to LOW.
- LOW (sclk=0):
  - divcnt counts 0..CLKDIV-1.
  - At the edge where divcnt=CLKDIV-1: sclk<=1, shift miso into the LSB of the rx shift register, divcnt<=0, go to HIGH.
- HIGH (sclk=1):
  - At the edge where divcnt=CLKDIV-1: sclk<=0, divcnt<=0.
  - If bitcnt=WIDTH-1: go to HOLD.
  - Else: bitcnt++, shift tx left, mosi<=next bit, go to LOW.
  - mosi therefore changes only on the same edge as sclk falls and has CLKDIV cycles of setup before the next rise.
- HOLD (sclk=0, cs=0):
  - CLKDIV cycles of cs hold time.
  - At the edge where divcnt=CLKDIV-1: cs<=1, rxdata<=rx shift register, done<=1, busy<=0, mosi<=0, go to IDLE.
- Timing:
  - cs is low for exactly (2*WIDTH+1)*CLKDIV cycles.
  - done is high in the first cycle cs is high again, with busy=0 in that cycle.
  - The default config (WIDTH=8, CLKDIV=4) gives 68 cycles.
- done is forced low every cycle except the completion cycle.
- start in the done cycle is accepted, allowing back-to-back transfers. cs then re-asserts on the next edge after one high cycle.
- start while busy=1 is ignored; it is not queued and txdata is not re-latched.
- Changes to txdata after acceptance do not affect the transfer in progress.
- miso is sampled only on sclk-rise edges; miso activity at any other time has no effect.
- rxdata holds its value between transfers and is not cleared by a new start.
- CLKDIV=1: sclk toggles every clk cycle and all the rules above still apply.

Test Plan:
- Loopback (miso tied to mosi), CLKDIV=2, txdata=8'hA5, start pulse -> cs low for 34 cycles; exactly 8 sclk rises; mosi at each rise = 1,0,1,0,0,1,0,1; done one cycle with rxdata=8'hA5.
- Peripheral model (loads 8'h3C on cs fall, shifts on sclk fall), txdata=8'h00 -> rxdata=8'h3C at done; cs=1 and sclk=0 in the done cycle.
- start held high continuously, CLKDIV=1, txdata=8'hFF then 8'h01 -> two transfers with exactly one cs-high cycle between them; rxdata=8'hFF then 8'h01 (loopback).
- Extra start pulses mid-transfer plus txdata changed to 8'h00 -> still exactly one done; rxdata equals the originally latched word (loopback).
- reset asserted after the 3rd sclk rise -> next edge cs=1, sclk=0, busy=0, rxdata=0, no done; a subsequent start with 8'h5A completes normally with rxdata=8'h5A.
- Idle for 100 cycles with miso toggling -> sclk=0, cs=1, done=0, rxdata unchanged.
